// File: rtl/pipe_skid_buffer_pkg.sv
// +--------------------------------------------------------------------+
// | pipe_skid_buffer_pkg                                               |
// | State encodings shared by the skid buffer and its controller.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package pipe_skid_buffer_pkg;

    localparam int unsigned c_STATE_W = 2;

    // The encoding doubles as the occupancy count; 2'd3 is illegal.
    typedef enum logic [c_STATE_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_buffer_if.sv
// +--------------------------------------------------------------------+
// | pipe_skid_buffer_if                                                |
// | Valid/ready link, flush and occupancy of the skid buffer.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface pipe_skid_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_ctrl.sv
// +--------------------------------------------------------------------+
// | pipe_skid_ctrl                                                     |
// | State register and next-state/load-enable logic of the skid buffer.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_skid_ctrl
    import pipe_skid_buffer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] count,
    output logic       load_m,
    output logic       load_s,
    output logic       m_from_s
);

    skid_state_t r_state;
    logic        r_started;
    logic        w_in_xfer;
    logic        w_out_xfer;

    // in_ready stays low until the first edge after reset is released.
    assign in_ready   = r_started & ((r_state == ST_EMPTY) | (r_state == ST_BUSY));
    assign out_valid  = (r_state == ST_BUSY) | (r_state == ST_FULL);
    assign count      = r_state;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: load_m = w_in_xfer;
                ST_BUSY: begin
                    load_s = w_in_xfer & ~w_out_xfer;
                    load_m = w_in_xfer &  w_out_xfer;
                end
                ST_FULL: begin
                    load_m   = w_out_xfer;
                    m_from_s = w_out_xfer;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_EMPTY;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (flush) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: if (w_in_xfer) r_state <= ST_BUSY;
                    ST_BUSY: begin
                        if (w_in_xfer && !w_out_xfer)      r_state <= ST_FULL;
                        else if (!w_in_xfer && w_out_xfer) r_state <= ST_EMPTY;
                    end
                    ST_FULL:  if (w_out_xfer) r_state <= ST_BUSY;
                    default:  r_state <= ST_EMPTY;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_skid_buffer.sv
// +--------------------------------------------------------------------+
// | pipe_skid_buffer                                                   |
// | Two-entry skid buffer: main (head) and skid data registers.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    pipe_skid_buffer_if.slave bus
);

    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_s;
    logic             w_load_m;
    logic             w_load_s;
    logic             w_m_from_s;

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .count     (bus.count),
        .load_m    (w_load_m),
        .load_s    (w_load_s),
        .m_from_s  (w_m_from_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m <= RESET_VALUE;
            r_s <= RESET_VALUE;
        end else begin
            if (w_load_m) r_m <= w_m_from_s ? r_s : bus.in_data;
            if (w_load_s) r_s <= bus.in_data;
        end
    end

    assign bus.out_data = r_m;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
// +--------------------------------------------------------------------+
// | tb_pipe_skid_buffer                                                |
// | Directed and random stimulus against a queue-based reference.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipe_skid_buffer;

    localparam logic [31:0] c_RV = 32'hDEADBEEF;

    logic clk;
    logic reset;

    pipe_skid_buffer_if #(.WIDTH(32)) bus ();

    pipe_skid_buffer #(
        .WIDTH       (32),
        .RESET_VALUE (c_RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] q[$];
    bit          up = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input bit iv, input logic [31:0] d, input bit ordy, input bit fl);
        bit exp_ir;
        bit do_in;
        bit do_out;
        @(negedge clk);
        exp_ir = up && (q.size() < 2);
        check("in_ready",  32'(bus.in_ready),  32'(exp_ir));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check("count",     32'(bus.count),     32'(q.size()));
        if (q.size() != 0) check("out_data", bus.out_data, q[0]);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        do_out = (q.size() != 0) && ordy;
        do_in  = iv && exp_ir;
        if (fl) begin
            q.delete();
        end else begin
            if (do_out) void'(q.pop_front());
            if (do_in)  q.push_back(d);
        end
        up = 1'b1;
    endtask

    // Assert reset mid-cycle with the given inputs applied, then release it.
    task automatic do_reset(input bit iv, input logic [31:0] d, input bit ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out_data",  bus.out_data,          c_RV);
        check("rst_out_valid", 32'(bus.out_valid),    32'd0);
        check("rst_count",     32'(bus.count),        32'd0);
        check("rst_in_ready",  32'(bus.in_ready),     32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_count", 32'(bus.count),       32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        q.delete();
        up = 1'b0;
        #1;
        check("rst_rel_in_ready", 32'(bus.in_ready),  32'd0);
        check("rst_rel_data",     bus.out_data,       c_RV);
        @(posedge clk);
        up = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        do_reset(1'b0, 32'h0, 1'b0);

        // Empty with out_ready high does nothing.
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming 0x1..0x10 at full rate.
        for (int i = 1; i <= 16; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall: A, B fill the buffer, C is presented while full.
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with 0x55 offered in the same cycle.
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h55, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h66, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset while full, then reset during a simultaneous push/pop in BUSY.
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 1'b0, 1'b0);
        do_reset(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h99, 1'b0, 1'b0);
        do_reset(1'b1, 32'hAA, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'hBB, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
